nzcv_cond_stage: RTL and testbench



---
 rtl/cond_pkg.sv | 29 ++
 rtl/cond_eval.sv | 39 +++
 rtl/nzcv_cond_stage.sv | 142 ++++++++++++++
 tb/tb_nzcv_cond_stage.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cond_pkg.sv
// Shared definitions for ARMv8 condition evaluation: condition-code enum and
// NZCV bit positions within the 4-bit {N,Z,C,V} flags vector.
package cond_pkg;

    typedef enum logic [3:0] {
        EQ = 4'b0000,
        NE = 4'b0001,
        CS = 4'b0010,
        CC = 4'b0011,
        MI = 4'b0100,
        PL = 4'b0101,
        VS = 4'b0110,
        VC = 4'b0111,
        HI = 4'b1000,
        LS = 4'b1001,
        GE = 4'b1010,
        LT = 4'b1011,
        GT = 4'b1100,
        LE = 4'b1101,
        AL = 4'b1110,
        NV = 4'b1111
    } cond_e;

    localparam int NZCV_N = 3;
    localparam int NZCV_Z = 2;
    localparam int NZCV_C = 1;
    localparam int NZCV_V = 0;

endpackage

// File: rtl/cond_eval.sv
// Combinational ARMv8 condition-code evaluator: (cond, nzcv) -> taken.
// Shared with the conditional-select path.
module cond_eval
    import cond_pkg::*;
(
    input  cond_e      i_cond,
    input  logic [3:0] i_nzcv,
    output logic       o_taken
);

    logic f_n, f_z, f_c, f_v;

    assign f_n = i_nzcv[NZCV_N];
    assign f_z = i_nzcv[NZCV_Z];
    assign f_c = i_nzcv[NZCV_C];
    assign f_v = i_nzcv[NZCV_V];

    always_comb begin
        o_taken = 1'b1;
        case (i_cond)
            EQ: o_taken = f_z;
            NE: o_taken = ~f_z;
            CS: o_taken = f_c;
            CC: o_taken = ~f_c;
            MI: o_taken = f_n;
            PL: o_taken = ~f_n;
            VS: o_taken = f_v;
            VC: o_taken = ~f_v;
            HI: o_taken = f_c & ~f_z;
            LS: o_taken = ~(f_c & ~f_z);
            GE: o_taken = (f_n == f_v);
            LT: o_taken = (f_n != f_v);
            GT: o_taken = ~f_z & (f_n == f_v);
            LE: o_taken = ~(~f_z & (f_n == f_v));
            default: o_taken = 1'b1; // AL and NV both execute unconditionally
        endcase
    end

endmodule

// File: rtl/nzcv_cond_stage.sv
// Execute-to-writeback stage: owns the architectural NZCV register, evaluates
// each instruction's condition on pre-update flags, and registers the result.
// Define COND_SKID_EN for a one-entry skid buffer with a registered o_ready.
module nzcv_cond_stage
    import cond_pkg::*;
#(
    parameter int N = 64
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [N-1:0] i_result,
    input  logic [3:0]   i_nzcv,
    input  logic         i_set_flags,
    input  logic [3:0]   i_cond,
    input  logic         i_flush,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [N-1:0] o_result,
    output logic         o_taken,
    output logic [3:0]   o_nzcv
);

    logic [3:0]   flags_q, flags_d;
    logic         out_valid_q, out_valid_d;
    logic [N-1:0] out_result_q, out_result_d;
    logic         out_taken_q, out_taken_d;
    // Keeps o_ready low while reset is held and for the first edge after it
    logic         alive_q, alive_d;

    logic accept;
    logic xfer;
    logic taken_new;

    cond_eval u_eval (
        .i_cond  (cond_e'(i_cond)),
        .i_nzcv  (flags_q),
        .o_taken (taken_new)
    );

    assign accept = i_valid & o_ready;
    assign xfer   = out_valid_q & i_ready;

    assign o_valid  = out_valid_q;
    assign o_result = out_result_q;
    assign o_taken  = out_taken_q;
    assign o_nzcv   = flags_q;

    always_comb begin
        alive_d = 1'b1;
        flags_d = flags_q;
        if (accept && i_set_flags) begin
            flags_d = i_nzcv;
        end
    end

`ifdef COND_SKID_EN
    logic         skid_valid_q, skid_valid_d;
    logic [N-1:0] skid_result_q, skid_result_d;
    logic         skid_taken_q, skid_taken_d;

    assign o_ready = alive_q & ~skid_valid_q & ~i_flush;

    always_comb begin
        out_valid_d   = out_valid_q;
        out_result_d  = out_result_q;
        out_taken_d   = out_taken_q;
        skid_valid_d  = skid_valid_q;
        skid_result_d = skid_result_q;
        skid_taken_d  = skid_taken_q;
        if (i_flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!out_valid_q || xfer) begin
            // Output slot frees up: skid entry is older than any new accept
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_result_d = skid_result_q;
                out_taken_d  = skid_taken_q;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                out_valid_d  = 1'b1;
                out_result_d = i_result;
                out_taken_d  = taken_new;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_valid_d  = 1'b1;
            skid_result_d = i_result;
            skid_taken_d  = taken_new;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            skid_valid_q  <= 1'b0;
            skid_result_q <= '0;
            skid_taken_q  <= 1'b0;
        end else begin
            skid_valid_q  <= skid_valid_d;
            skid_result_q <= skid_result_d;
            skid_taken_q  <= skid_taken_d;
        end
    end
`else
    assign o_ready = alive_q & (~out_valid_q | i_ready) & ~i_flush;

    always_comb begin
        out_valid_d  = out_valid_q;
        out_result_d = out_result_q;
        out_taken_d  = out_taken_q;
        if (i_flush) begin
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_valid_d  = 1'b1;
            out_result_d = i_result;
            out_taken_d  = taken_new;
        end else if (xfer) begin
            out_valid_d = 1'b0;
        end
    end
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            alive_q      <= 1'b0;
            flags_q      <= 4'b0000;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_taken_q  <= 1'b0;
        end else begin
            alive_q      <= alive_d;
            flags_q      <= flags_d;
            out_valid_q  <= out_valid_d;
            out_result_q <= out_result_d;
            out_taken_q  <= out_taken_d;
        end
    end

endmodule

// File: tb/tb_nzcv_cond_stage.sv
// Self-checking bench for nzcv_cond_stage: directed vector table, full cond x
// flags sweep, stall/flush/reset sequences, scoreboard-checked outputs.
module tb_nzcv_cond_stage;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_valid;
    logic        o_ready;
    logic [63:0] i_result;
    logic [3:0]  i_nzcv;
    logic        i_set_flags;
    logic [3:0]  i_cond;
    logic        i_flush;
    logic        o_valid;
    logic        i_ready;
    logic [63:0] o_result;
    logic        o_taken;
    logic [3:0]  o_nzcv;

    nzcv_cond_stage #(.N(64)) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_result    (i_result),
        .i_nzcv      (i_nzcv),
        .i_set_flags (i_set_flags),
        .i_cond      (i_cond),
        .i_flush     (i_flush),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_result    (o_result),
        .o_taken     (o_taken),
        .o_nzcv      (o_nzcv)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [63:0] result;
        logic [3:0]  nzcv;
        logic        set;
        logic [3:0]  cond;
        logic        exp_taken;
    } vec_t;

    typedef struct {
        logic [63:0] result;
        logic        taken;
    } exp_t;

    exp_t       sb[$];
    logic [3:0] mflags;
    bit         in_reset;
    int         n_cmp;
    int         n_fail;
    vec_t       tbl[18];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v, r;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        case (c[3:1])
            3'd0: r = z;
            3'd1: r = cy;
            3'd2: r = n;
            3'd3: r = v;
            3'd4: r = cy & ~z;
            3'd5: r = (n == v);
            3'd6: r = ~z & (n == v);
            default: r = 1'b1;
        endcase
        if (c[0] && c[3:1] != 3'd7) r = ~r;
        return r;
    endfunction

    // One clock of stimulus; the model is updated only after the accepting edge.
    task automatic drive_cycle(input logic v, input logic [63:0] r, input logic [3:0] nz,
                               input logic s, input logic [3:0] c, input logic et,
                               output logic acc, output logic rdy);
        @(negedge i_clk);
        i_valid = v; i_result = r; i_nzcv = nz; i_set_flags = s; i_cond = c;
        #1;
        rdy = o_ready;
        acc = v && rdy;
        @(posedge i_clk);
        #1;
        if (acc) begin
            sb.push_back('{r, et});
            if (s) mflags = nz;
        end
        i_valid = 1'b0;
    endtask

    task automatic send(input logic [63:0] r, input logic [3:0] nz, input logic s,
                        input logic [3:0] c, input logic et, output int tries);
        logic acc, rdy;
        acc = 1'b0;
        tries = 0;
        while (!acc && tries < 20) begin
            drive_cycle(1'b1, r, nz, s, c, et, acc, rdy);
            tries++;
        end
        if (!acc) chk("send_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_drain();
        logic acc, rdy;
        for (int k = 0; k < 10 && sb.size() != 0; k++)
            drive_cycle(1'b0, 64'd0, 4'd0, 1'b0, 4'd0, 1'b0, acc, rdy);
        chk("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    // Output monitor, sampling just before each rising edge.
    always begin
        @(negedge i_clk);
        #4;
        if (!in_reset) begin
            chk("nzcv", {60'd0, o_nzcv}, {60'd0, mflags});
            chk("valid", {63'd0, o_valid}, {63'd0, sb.size() != 0});
            if (o_valid && sb.size() != 0) begin
                chk("result", o_result, sb[0].result);
                chk("taken", {63'd0, o_taken}, {63'd0, sb[0].taken});
                if (i_ready) void'(sb.pop_front());
            end
            if (i_flush) sb.delete();
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   tries;
        logic acc, rdy;
        int   accepts;

        tbl[0]  = '{64'h0,    4'b0110, 1'b1, 4'b1110, 1'b1}; // ADDS -> 0
        tbl[1]  = '{64'h5,    4'b0100, 1'b1, 4'b1110, 1'b1}; // SUBS, Z=1
        tbl[2]  = '{64'h6,    4'b0000, 1'b0, 4'b0000, 1'b1}; // B.EQ
        tbl[3]  = '{64'h7,    4'b0000, 1'b0, 4'b0001, 1'b0}; // B.NE
        tbl[4]  = '{64'h8,    4'b0000, 1'b1, 4'b1110, 1'b1}; // flags -> 0000
        tbl[5]  = '{64'h9,    4'b0100, 1'b1, 4'b0000, 1'b0}; // EQ on pre-update flags
        tbl[6]  = '{64'hA,    4'b0000, 1'b0, 4'b0000, 1'b1}; // sees new Z
        tbl[7]  = '{64'hB,    4'b1000, 1'b1, 4'b1110, 1'b1}; // N=1 V=0
        tbl[8]  = '{64'hC,    4'b0000, 1'b0, 4'b1010, 1'b0}; // GE
        tbl[9]  = '{64'hD,    4'b0000, 1'b0, 4'b1011, 1'b1}; // LT
        tbl[10] = '{64'hE,    4'b1001, 1'b1, 4'b1110, 1'b1}; // N=1 V=1
        tbl[11] = '{64'hF,    4'b0000, 1'b0, 4'b1010, 1'b1}; // GE
        tbl[12] = '{64'h10,   4'b0000, 1'b0, 4'b1011, 1'b0}; // LT
        tbl[13] = '{64'h11,   4'b0000, 1'b0, 4'b1100, 1'b1}; // GT
        tbl[14] = '{64'h12,   4'b0000, 1'b0, 4'b1101, 1'b0}; // LE
        tbl[15] = '{64'h13,   4'b0000, 1'b0, 4'b1000, 1'b0}; // HI, C=0
        tbl[16] = '{64'h14,   4'b0000, 1'b0, 4'b1001, 1'b1}; // LS
        tbl[17] = '{64'hDEAD, 4'b0000, 1'b0, 4'b1111, 1'b1}; // NV executes

        n_cmp = 0; n_fail = 0; mflags = 4'b0000; in_reset = 1'b1;
        i_rst_n = 1'b0; i_valid = 1'b0; i_result = '0; i_nzcv = '0;
        i_set_flags = 1'b0; i_cond = '0; i_flush = 1'b0; i_ready = 1'b1;

        repeat (3) @(negedge i_clk);
        chk("rst_valid", {63'd0, o_valid}, 64'd0);
        chk("rst_result", o_result, 64'd0);
        chk("rst_taken", {63'd0, o_taken}, 64'd0);
        chk("rst_nzcv", {60'd0, o_nzcv}, 64'd0);
        chk("rst_ready", {63'd0, o_ready}, 64'd0);
        i_rst_n = 1'b1;
        in_reset = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;

        // Directed table, back-to-back at full throughput
        for (int i = 0; i < 18; i++) begin
            send(tbl[i].result, tbl[i].nzcv, tbl[i].set, tbl[i].cond, tbl[i].exp_taken, tries);
            chk("throughput", 64'(tries), 64'd1);
        end
        wait_drain();

        // All conditions over all flag values
        for (int f = 0; f < 16; f++) begin
            send(64'(f) << 8, 4'(f), 1'b1, 4'b1110, 1'b1, tries);
            for (int c = 0; c < 16; c++)
                send({48'hC0DE, 8'(f), 8'(c)}, 4'd0, 1'b0, 4'(c), ref_cond(4'(c), mflags), tries);
        end
        wait_drain();

        // Output stall with i_valid held high
        i_ready = 1'b0;
        accepts = 0;
        drive_cycle(1'b1, 64'hA1, 4'b0010, 1'b1, 4'b1110, 1'b1, acc, rdy);
        chk("stall_acc0", {63'd0, acc}, 64'd1);
        if (acc) accepts++;
        drive_cycle(1'b1, 64'hB2, 4'b0000, 1'b0, 4'b0010, 1'b1, acc, rdy);
`ifdef COND_SKID_EN
        chk("stall_rdy1", {63'd0, rdy}, 64'd1);
`else
        chk("stall_rdy1", {63'd0, rdy}, 64'd0);
`endif
        if (acc) accepts++;
        drive_cycle(1'b1, 64'hC3, 4'b0000, 1'b0, 4'b1110, 1'b1, acc, rdy);
        chk("stall_rdy2", {63'd0, rdy}, 64'd0);
        if (acc) accepts++;
`ifdef COND_SKID_EN
        chk("stall_accepts", 64'(accepts), 64'd2);
`else
        chk("stall_accepts", 64'(accepts), 64'd1);
`endif
        i_ready = 1'b1;
        wait_drain();

        // Flush with output full (and skid full when present)
        i_ready = 1'b0;
        drive_cycle(1'b1, 64'h55, 4'b1010, 1'b1, 4'b1110, 1'b1, acc, rdy);
        drive_cycle(1'b1, 64'h66, 4'b0000, 1'b0, 4'b1110, 1'b1, acc, rdy);
        @(negedge i_clk);
        i_flush = 1'b1; i_valid = 1'b1; i_set_flags = 1'b1; i_nzcv = 4'b1111; i_cond = 4'b1110;
        #1;
        chk("flush_ready", {63'd0, o_ready}, 64'd0);
        @(posedge i_clk);
        #1;
        i_flush = 1'b0; i_valid = 1'b0;
        chk("flush_valid", {63'd0, o_valid}, 64'd0);
        chk("flush_nzcv", {60'd0, o_nzcv}, 64'b1010);
        i_ready = 1'b1;
        wait_drain();

        // Asynchronous reset mid-operation
        i_ready = 1'b0;
        drive_cycle(1'b1, 64'h77, 4'b0110, 1'b1, 4'b1110, 1'b1, acc, rdy);
        #2;
        in_reset = 1'b1;
        i_rst_n = 1'b0;
        #1;
        chk("midrst_valid", {63'd0, o_valid}, 64'd0);
        chk("midrst_nzcv", {60'd0, o_nzcv}, 64'd0);
        chk("midrst_ready", {63'd0, o_ready}, 64'd0);
        sb.delete();
        mflags = 4'b0000;
        @(negedge i_clk);
        i_rst_n = 1'b1;
        in_reset = 1'b0;
        i_ready = 1'b1;
        send(64'h88, 4'b0000, 1'b0, 4'b0000, 1'b0, tries);
        wait_drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
